// File: rtl/redmule_tiler_seq.sv
// Tiling/configuration calculator for a GEMM job: decodes sizes into iteration counts,
// leftovers and strides, then derives store/beat totals with one shared shift-add multiplier.
module redmule_tiler_seq #(
   parameter int unsigned ARRAY_HEIGHT = 4,
   parameter int unsigned ARRAY_WIDTH  = 4,
   parameter int unsigned PIPE_REGS    = 1,
   parameter int unsigned TOT_DEPTH    = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        ready_o,
   input  logic [15:0] m_size_i,
   input  logic [15:0] n_size_i,
   input  logic [15:0] k_size_i,
   input  logic [1:0]  in_fmt_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [15:0] x_rows_iter_o,
   output logic [15:0] x_cols_iter_o,
   output logic [15:0] w_cols_iter_o,
   output logic [7:0]  x_rows_lftovr_o,
   output logic [7:0]  x_cols_lftovr_o,
   output logic [7:0]  w_cols_lftovr_o,
   output logic [15:0] tot_stores_o,
   output logic [31:0] w_tot_len_o,
   output logic [31:0] x_d1_stride_o,
   output logic [31:0] w_d0_stride_o,
   output logic [1:0]  left_params_o,
   output logic        err_o,
   output logic        ovf_o
);
   localparam int unsigned TILE   = (PIPE_REGS + 1) * ARRAY_HEIGHT;
   localparam int unsigned LOG_AW = $clog2(ARRAY_WIDTH);
   localparam int unsigned LOG_D  = $clog2(TOT_DEPTH);

   typedef enum logic [1:0] {FP8 = 2'd0, FP16 = 2'd1, FP8ALT = 2'd2, FP16ALT = 2'd3} gemm_fmt_e;
   typedef enum logic [2:0] {IDLE, DECODE, MUL1, MUL2, DONE} state_e;

   state_e      state, next_state;
   logic [15:0] m_q, n_q, k_q;
   logic [1:0]  fmt_q;
   logic [3:0]  cnt;
   logic [47:0] mcand, acc, acc_sum;
   logic [15:0] mplier;
   logic        zero_job, wide_fmt;

   function automatic logic [15:0] ceil_div(input logic [15:0] a, input int unsigned lg);
      logic [15:0] mask;
      mask = (16'd1 << lg) - 16'd1;
      return (a >> lg) + {15'd0, |(a & mask)};
   endfunction

   function automatic logic [7:0] lftovr(input logic [15:0] a, input int unsigned lg);
      logic [15:0] r;
      r = a & ((16'd1 << lg) - 16'd1);
      return r[7:0];
   endfunction

   function automatic logic [31:0] stride(input logic [15:0] a, input logic two_bytes);
      return two_bytes ? {15'd0, a, 1'b0} : {16'd0, a};
   endfunction

   assign zero_job = (m_q == 16'd0) || (n_q == 16'd0) || (k_q == 16'd0);
   assign wide_fmt = (fmt_q == FP16) || (fmt_q == FP16ALT);
   // One radix-2 step: add the shifted multiplicand when the current multiplier bit is set
   assign acc_sum  = acc + (mplier[0] ? mcand : 48'd0);

   assign ready_o = (state == IDLE);
   assign valid_o = (state == DONE);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_i) next_state = DECODE;
         DECODE:  next_state = zero_job ? DONE : MUL1;
         MUL1:    if (cnt == 4'd15) next_state = MUL2;
         MUL2:    if (cnt == 4'd15) next_state = DONE;
         DONE:    if (ready_i) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_q <= '0; n_q <= '0; k_q <= '0; fmt_q <= '0;
         cnt <= '0; mcand <= '0; acc <= '0; mplier <= '0;
         x_rows_iter_o <= '0; x_cols_iter_o <= '0; w_cols_iter_o <= '0;
         x_rows_lftovr_o <= '0; x_cols_lftovr_o <= '0; w_cols_lftovr_o <= '0;
         tot_stores_o <= '0; w_tot_len_o <= '0;
         x_d1_stride_o <= '0; w_d0_stride_o <= '0;
         left_params_o <= '0; err_o <= 1'b0; ovf_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               m_q <= m_size_i; n_q <= n_size_i; k_q <= k_size_i; fmt_q <= in_fmt_i;
               err_o <= 1'b0;
               ovf_o <= 1'b0;
            end
            DECODE: begin
               cnt <= '0;
               acc <= '0;
               if (zero_job) begin
                  err_o <= 1'b1;
                  x_rows_iter_o <= '0; x_cols_iter_o <= '0; w_cols_iter_o <= '0;
                  x_rows_lftovr_o <= '0; x_cols_lftovr_o <= '0; w_cols_lftovr_o <= '0;
                  tot_stores_o <= '0; w_tot_len_o <= '0;
                  x_d1_stride_o <= '0; w_d0_stride_o <= '0;
                  left_params_o <= '0;
               end else begin
                  x_rows_iter_o   <= ceil_div(m_q, LOG_AW);
                  x_rows_lftovr_o <= lftovr(m_q, LOG_AW);
                  x_cols_iter_o   <= ceil_div(n_q, LOG_D);
                  x_cols_lftovr_o <= lftovr(n_q, LOG_D);
                  w_cols_iter_o   <= ceil_div(k_q, LOG_D);
                  w_cols_lftovr_o <= lftovr(k_q, LOG_D);
                  x_d1_stride_o   <= stride(n_q, wide_fmt);
                  w_d0_stride_o   <= stride(k_q, wide_fmt);
                  left_params_o   <= {n_q < 16'(ARRAY_HEIGHT), k_q < 16'(TILE)};
                  mcand           <= {32'd0, ceil_div(m_q, LOG_AW)};
                  mplier          <= ceil_div(k_q, LOG_D);
               end
            end
            MUL1: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  // P1 becomes the multiplicand of the second product
                  tot_stores_o <= acc_sum[15:0];
                  ovf_o        <= ovf_o | (|acc_sum[31:16]);
                  mcand        <= {16'd0, acc_sum[31:0]};
                  mplier       <= x_cols_iter_o;
                  acc          <= '0;
               end else begin
                  acc    <= acc_sum;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
            end
            MUL2: begin
               cnt    <= cnt + 4'd1;
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == 4'd15) begin
                  w_tot_len_o <= acc_sum[31:0];
                  ovf_o       <= ovf_o | (|acc_sum[47:32]);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
